hazard_stall_ctrl: RTL

- Hazard/stall controller for the 5-stage MULT2 pipeline.
- Observes the ID stage and the outputs of the ID/EX pipeline register.
- Drives the enables and bubble/flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- Handles three events: load-use hazards, the multi-cycle multiplier occupying EX, and taken-branch flushes resolved in MEM.

---
 rtl/hazard_stall_ctrl_pkg.sv | 20 ++
 rtl/hazard_stall_ctrl_if.sv | 33 +++
 rtl/hazard_stall_ctrl_mult_occupancy_fsm.sv | 85 ++++++++
 rtl/hazard_stall_ctrl.sv | 88 ++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the MULT2 pipeline hazard/stall controller.
// Holds the register-index width, the x0 index and the multiplier FSM state encoding.
package pipeline_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] X0_IDX = '0;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

  // True when a register written by EX is the one being read. x0 never matches.
  function automatic logic reg_match(input logic [REG_ADDR_W-1:0] wr_idx,
                                     input logic [REG_ADDR_W-1:0] rd_idx);
    return (wr_idx != X0_IDX) && (wr_idx == rd_idx);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side view of the hazard controller: ID/EX/MEM observations in,
// register enables and bubble/flush controls out.
interface hazard_stall_ctrl_if;
  import pipeline_pkg::*;

  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_memread;
  logic                  ex_is_mult;
  logic                  mem_branch_taken;

  logic                  pc_en;
  logic                  if_id_en;
  logic                  if_id_flush;
  logic                  id_ex_en;
  logic                  id_ex_bubble;
  logic                  ex_mem_bubble;
  logic                  mult_done;

  // The pipeline datapath drives observations and consumes the controls.
  modport master (
    output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_memread, ex_is_mult, mem_branch_taken,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_bubble, mult_done
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_memread, ex_is_mult, mem_branch_taken,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_bubble, mult_done
  );

endinterface

// File: rtl/hazard_stall_ctrl_mult_occupancy_fsm.sv
// Tracks how long a MUL has occupied EX and raises a stall request until its
// final cycle, where it pulses mult_done instead.
module mult_occupancy_fsm
  import pipeline_pkg::*;
#(
  parameter int MULT_LAT = 2,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic arst_n,
  input  logic ex_is_mult,
  input  logic flush,
  output logic idle,
  output logic mult_stall,
  output logic mult_done
);

  localparam bit               MULTI_CYCLE = (MULT_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_INIT    = MULTI_CYCLE ? CNT_W'(MULT_LAT - 2) : '0;

  mul_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A taken branch aborts any MUL in flight, including one just arriving.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_is_mult && MULTI_CYCLE) begin
            state_nxt = MUL_BUSY;
            cnt_nxt   = CNT_INIT;
          end
        end
        MUL_BUSY: begin
          if (cnt == '0) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    idle       = (state == IDLE);
    mult_stall = 1'b0;
    mult_done  = 1'b0;
    if (!flush) begin
      case (state)
        IDLE: begin
          if (ex_is_mult) begin
            mult_stall = MULTI_CYCLE;
            mult_done  = !MULTI_CYCLE;
          end
        end
        MUL_BUSY: begin
          mult_stall = (cnt != '0);
          mult_done  = (cnt == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage MULT2 pipeline: branch flush > MUL stall > load-use.
// Optional HAZARD_PERF_CNT_EN adds perf_stall_cycles / perf_flush_cnt counters.
module hazard_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int MULT_LAT = 2,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                arst_n,
  hazard_stall_ctrl_if.slave  bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]         perf_stall_cycles,
  output logic [31:0]         perf_flush_cnt
`endif
);

  logic fsm_idle;
  logic mult_stall;
  logic fsm_done;
  logic load_use;

  mult_occupancy_fsm #(
    .MULT_LAT (MULT_LAT),
    .CNT_W    (CNT_W)
  ) u_mult_fsm (
    .clk        (clk),
    .arst_n     (arst_n),
    .ex_is_mult (bus.ex_is_mult),
    .flush      (bus.mem_branch_taken),
    .idle       (fsm_idle),
    .mult_stall (mult_stall),
    .mult_done  (fsm_done)
  );

  always_comb begin
    load_use = bus.ex_memread &&
               (reg_match(bus.ex_rd, bus.id_rs1) ||
                (bus.id_uses_rs2 && reg_match(bus.ex_rd, bus.id_rs2)));
  end

  // Outputs stay at their pass-through defaults while reset is held, whatever the inputs.
  always_comb begin
    bus.pc_en         = 1'b1;
    bus.if_id_en      = 1'b1;
    bus.if_id_flush   = 1'b0;
    bus.id_ex_en      = 1'b1;
    bus.id_ex_bubble  = 1'b0;
    bus.ex_mem_bubble = 1'b0;
    bus.mult_done     = 1'b0;
    if (arst_n) begin
      if (bus.mem_branch_taken) begin
        bus.if_id_flush   = 1'b1;
        bus.id_ex_bubble  = 1'b1;
        bus.ex_mem_bubble = 1'b1;
      end else if (mult_stall) begin
        bus.pc_en         = 1'b0;
        bus.if_id_en      = 1'b0;
        bus.id_ex_en      = 1'b0;
        bus.ex_mem_bubble = 1'b1;
      end else if (fsm_done) begin
        bus.mult_done     = 1'b1;
      end else if (fsm_idle && !bus.ex_is_mult && load_use) begin
        bus.pc_en         = 1'b0;
        bus.if_id_en      = 1'b0;
        bus.id_ex_bubble  = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      perf_stall_cycles <= '0;
      perf_flush_cnt    <= '0;
    end else begin
      if (!bus.pc_en) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (bus.mem_branch_taken) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
